bcd_disp_scan: RTL and testbench

BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

---
 rtl/bcd_disp_scan.sv | 112 +++++++++++
 tb/tb_bcd_disp_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_disp_scan.sv
// Four-digit multiplexed 7-segment driver for packed BCD, with sticky invalid-digit flag.
// Latency: a load is visible on seg one cycle later; an/seg decode registered state only.
// Backpressure: none; load is a strobe accepted every cycle. Option: LEADING_ZERO_BLANK_EN.
module bcd_disp_scan #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        load,
    input  logic        err_clr,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);

    localparam int unsigned    PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);

    logic [15:0]   shadow;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          din_bad;
    logic          blank;

    function automatic logic nib_bad(input logic [3:0] n);
        return n[3] & (n[2] | n[1]);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    assign din_bad = nib_bad(din[3:0])  | nib_bad(din[7:4]) |
                     nib_bad(din[11:8]) | nib_bad(din[15:12]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= din;
        end
    end

    // Scan timing is free-running; loads and err_clr never touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PMAX) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (load && din_bad) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    always_comb begin
        nib = shadow[3:0];
        case (idx)
            2'd1:    nib = shadow[7:4];
            2'd2:    nib = shadow[11:8];
            2'd3:    nib = shadow[15:12];
            default: nib = shadow[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Units never blank; an invalid nibble is non-zero so it can never blank either.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (shadow[15:4]  == 12'h000);
            2'd2:    blank = (shadow[15:8]  == 8'h00);
            2'd3:    blank = (shadow[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg = blank ? 7'b0000000 : seg7(nib);
    assign an  = 4'b0001 << idx;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Randomized bench for bcd_disp_scan: cycle-count based reference model plus literal spot checks.
module tb_bcd_disp_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        load = 1'b0;
    logic        err_clr = 1'b0;
    logic [6:0]  seg4, seg1;
    logic [3:0]  an4, an1;
    logic        err4, err1;

    int checks = 0;
    int errors = 0;

    bcd_disp_scan #(.SCAN_DIV(4)) u4 (
        .clk(clk), .reset(reset), .din(din), .load(load), .err_clr(err_clr),
        .seg(seg4), .an(an4), .err(err4)
    );
    bcd_disp_scan #(.SCAN_DIV(1)) u1 (
        .clk(clk), .reset(reset), .din(din), .load(load), .err_clr(err_clr),
        .seg(seg1), .an(an1), .err(err1)
    );

    always #5 clk = ~clk;

    // Reference model: digit shown is (edges since reset / SCAN_DIV) mod 4.
    int          m_cyc;
    logic [15:0] m_sh;
    logic        m_err;
    logic [6:0]  segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic logic m_bad(input logic [15:0] v);
        for (int k = 0; k < 4; k++)
            if (((v >> (4 * k)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] m_seg(input logic [15:0] sh, input int k);
        int v;
        v = int'((sh >> (4 * k)) & 16'hF);
        if (v > 9) return 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (sh >> (4 * k)) == 16'h0000) return 7'b0000000;
`endif
        return segtab[v];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc <= 0;
            m_sh  <= 16'h0000;
            m_err <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (load) m_sh <= din;
            if (load && m_bad(din)) m_err <= 1'b1;
            else if (err_clr)       m_err <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int i4, i1;
        i4 = (m_cyc / 4) % 4;
        i1 = m_cyc % 4;
        chk("model_an4",  {3'b000, an4},  {3'b000, 4'b0001 << i4});
        chk("model_seg4", seg4, m_seg(m_sh, i4));
        chk("model_err4", {6'd0, err4}, {6'd0, m_err});
        chk("model_an1",  {3'b000, an1},  {3'b000, 4'b0001 << i1});
        chk("model_seg1", seg1, m_seg(m_sh, i1));
        chk("model_err1", {6'd0, err1}, {6'd0, m_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle of digit 0 on the SCAN_DIV=4 instance.
    task automatic wait_digit0();
        logic [3:0] prev;
        prev = an4;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (prev == 4'b1000 && an4 == 4'b0001) return;
            prev = an4;
        end
        checks++;
        errors++;
        $display("FAIL wait_digit0: timeout, an=%b expected 0001 after 1000", an4);
    endtask

    task automatic load_val(input logic [15:0] v);
        din = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic mid_reset();
        din = 16'h4321;
        load = 1'b1;
        err_clr = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_an",  {3'b000, an4}, 7'b0000001);
        chk("rst_seg", seg4, 7'b1111110);
        chk("rst_err", {6'd0, err4}, 7'd0);
        #9;
        load = 1'b0;
        err_clr = 1'b0;
        reset = 1'b1;
        chk("rel_an", {3'b000, an4}, 7'b0000001);
        for (int i = 0; i < 4; i++) tick();
        chk("rel_an_next", {3'b000, an4}, 7'b0000010);
    endtask

    initial begin
        logic [3:0] an_seq [4];
        logic [6:0] seg_seq [4];
        an_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        #12;
        chk("reset_an",  {3'b000, an4}, 7'b0000001);
        chk("reset_seg", seg4, 7'b1111110);
        chk("reset_err", {6'd0, err4}, 7'd0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            chk("div1_rot", {3'b000, an1}, {3'b000, an_seq[i % 4]});
            tick();
        end

        load_val(16'h1234);
        seg_seq = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        wait_digit0();
        for (int i = 0; i < 20; i++) begin
            chk("scan_an",  {3'b000, an4}, {3'b000, an_seq[(i / 4) % 4]});
            chk("scan_seg", seg4, seg_seq[(i / 4) % 4]);
            tick();
        end

        wait_digit0();
        din = 16'h0009;
        load = 1'b1;
        tick();
        chk("lat_9", seg4, 7'b1111011);
        din = 16'h0008;
        tick();
        load = 1'b0;
        chk("lat_8", seg4, 7'b1111111);
        chk("lat_an", {3'b000, an4}, 7'b0000001);

        load_val(16'h00A5);
        chk("bad_err", {6'd0, err4}, 7'd1);
        wait_digit0();
        chk("bad_units", seg4, 7'b1011011);
        for (int i = 0; i < 4; i++) tick();
        chk("bad_tens", seg4, 7'b0000001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", {6'd0, err4}, 7'd0);
        err_clr = 1'b1;
        load_val(16'hF000);
        err_clr = 1'b0;
        chk("set_wins", {6'd0, err4}, 7'd1);

        load_val(16'h0007);
        wait_digit0();
        for (int i = 0; i < 16; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            chk("blank_seg", seg4, (i < 4) ? 7'b1110000 : 7'b0000000);
`else
            chk("blank_seg", seg4, (i < 4) ? 7'b1110000 : 7'b1111110);
`endif
            tick();
        end

        tick();
        mid_reset();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) din = 16'($urandom);
            else din = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            load = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) mid_reset();
            else tick();
        end
        load = 1'b0;
        err_clr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
